fifo_rd_drain: RTL and testbench

Read-side consumer for the team's dual-clock FIFO. It lives entirely in the read clock domain and pops words using the FIFO's `rinc`/`rdata`/`rempty` contract. It re-presents those words on a valid/ready stream through a 2-entry output buffer. It also provides a flush mode that empties the FIFO and the buffer while counting the discarded words.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/fifo_rd_skid.sv | 56 +++++
 rtl/fifo_rd_drain.sv | 89 ++++++++
 tb/tb_fifo_rd_drain.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and defaults for the FIFO read-side drain
package fifo_rd_pkg;

  localparam int FIFO_DSIZE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry in-order skid buffer with occupancy and clear
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [DSIZE-1:0] head
);

  logic [DSIZE-1:0] tail;

  // head is always the oldest entry; tail only holds data when occ == 2
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      occ <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= push_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail <= push_data;
            occ  <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      occ  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-domain FIFO consumer with valid/ready output and counted flush
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] drop_count
);

  rd_state_t        state;
  logic [1:0]       occ;
  logic [DSIZE-1:0] head;
  logic             xfer;

  // rinc depends only on registered state/occupancy and rempty, never on m_ready
  always_comb begin
    rinc = 1'b0;
    case (state)
      RUN:     rinc = en && !rempty && (occ < 2'd2);
      FLUSH:   rinc = !rempty;
      default: rinc = 1'b0;
    endcase
  end

  assign m_valid = (occ != 2'd0) && (state != FLUSH);
  assign m_data  = head;
  assign xfer    = m_valid && m_ready;
  assign busy    = (state != IDLE) || (occ != 2'd0);

  fifo_rd_skid #(
    .DSIZE(DSIZE)
  ) u_skid (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .clr       (state == FLUSH),
    .push      (rinc && (state == RUN)),
    .push_data (rdata),
    .pop       (xfer),
    .occ       (occ),
    .head      (head)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (flush)   state <= FLUSH;
          else if (en) state <= RUN;
        end
        RUN: begin
          if (flush)    state <= FLUSH;
          else if (!en) state <= IDLE;
        end
        FLUSH: begin
          if (rempty) state <= en ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In FLUSH the buffer is cleared every cycle, so occ is non-zero only on the entry cycle
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count   <= '0;
      drop_count <= '0;
    end else begin
      rd_count <= rd_count + CNT_W'(xfer);
      if (state == FLUSH)
        drop_count <= drop_count + CNT_W'(occ) + CNT_W'(rinc);
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - scoreboard bench for fifo_rd_drain against a behavioural FIFO model
module tb_fifo_rd_drain;
  import fifo_rd_pkg::*;

  localparam int CNT_W = 4;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             en, flush, m_ready;
  logic             rempty, rinc, m_valid, busy;
  logic [7:0]       rdata, m_data;
  logic [CNT_W-1:0] rd_count, drop_count;

  logic             wr_en;
  logic [7:0]       wr_data;
  logic [7:0]       fmem [0:63];
  logic [5:0]       wp, rp;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  int         obs_rd = 0;
  int         cyc = 0;
  int         bad_pop_n = 0;

  always #5 rclk = ~rclk;

  fifo_rd_drain #(
    .DSIZE(8),
    .CNT_W(CNT_W)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .en         (en),
    .flush      (flush),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .rd_count   (rd_count),
    .drop_count (drop_count)
  );

  // FIFO model with a registered empty flag, reset shared with the DUT
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wp     <= 6'd0;
      rp     <= 6'd0;
      rempty <= 1'b1;
    end else begin
      if (wr_en) fmem[wp] <= wr_data;
      wp     <= wp + 6'(wr_en);
      rp     <= rp + 6'(rinc);
      rempty <= ((wp + 6'(wr_en)) == (rp + 6'(rinc)));
    end
  end
  assign rdata = fmem[rp];

  always @(negedge rclk) begin
    cyc = cyc + 1;
    if (rrst_n) begin
      if (m_valid && m_ready) begin
        obs_q.push_back(m_data);
        obs_cyc.push_back(cyc);
      end
      if (rinc && rempty) bad_pop_n = bad_pop_n + 1;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00;
    tick(); tick();
    rrst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic write_words(input int n, input logic [7:0] base, input bit keep);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      if (keep) exp_q.push_back(base + 8'(i));
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic consume_obs();
    logic [7:0] e;
    while (obs_rd < obs_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %02h, none expected", obs_q[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin
          errors++;
          $display("FAIL stream_data: got %02h, expected %02h", obs_q[obs_rd], e);
        end
      end
      obs_rd++;
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      consume_obs();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00;
    repeat (5) tick();
    checks += 5;
    if (rinc !== 1'b0)       begin errors++; $display("FAIL reset_rinc: got %b, expected 0", rinc); end
    if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (rd_count !== '0)     begin errors++; $display("FAIL reset_rd_count: got %0d, expected 0", rd_count); end
    if (drop_count !== '0)   begin errors++; $display("FAIL reset_drop_count: got %0d, expected 0", drop_count); end
    en = 1'b1;
    rrst_n = 1'b1;
    tick(); tick();
    checks += 2;
    if (dut.state !== RUN) begin errors++; $display("FAIL release_state: got %0d, expected %0d", dut.state, RUN); end
    if (rinc !== 1'b0)     begin errors++; $display("FAIL release_rinc: got %b, expected 0", rinc); end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic test_streaming();
    int base_obs, base_bad;
    apply_reset();
    base_bad = bad_pop_n;
    en = 1'b1; m_ready = 1'b1;
    base_obs = obs_q.size();
    write_words(15, 8'h01, 1'b1);
    drain(100);
    repeat (3) tick();
    checks += 3;
    if (rd_count !== 4'd15) begin errors++; $display("FAIL stream_rd_count: got %0d, expected 15", rd_count); end
    if (obs_q.size() < base_obs + 15) begin
      errors++; $display("FAIL stream_span: got %0d words, expected 15", obs_q.size() - base_obs);
    end else if (obs_cyc[base_obs + 14] - obs_cyc[base_obs] != 14) begin
      errors++; $display("FAIL stream_span: got %0d cycles, expected 14", obs_cyc[base_obs + 14] - obs_cyc[base_obs]);
    end
    if (bad_pop_n != base_bad) begin errors++; $display("FAIL pop_while_empty: got %0d, expected 0", bad_pop_n - base_bad); end
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    apply_reset();
    en = 1'b1; m_ready = 1'b0;
    write_words(4, 8'h01, 1'b1);
    repeat (8) tick();
    checks += 4;
    if (dut.occ !== 2'd2)  begin errors++; $display("FAIL bp_occ: got %0d, expected 2", dut.occ); end
    if (rinc !== 1'b0)     begin errors++; $display("FAIL bp_rinc: got %b, expected 0", rinc); end
    if (m_valid !== 1'b1)  begin errors++; $display("FAIL bp_m_valid: got %b, expected 1", m_valid); end
    if (m_data !== 8'h01)  begin errors++; $display("FAIL bp_m_data: got %02h, expected 01", m_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_data !== 8'h01 || m_valid !== 1'b1 || rinc !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_hold: got unstable, expected stable"); end
    m_ready = 1'b1;
    drain(30);
    tick();
    checks++;
    if (rd_count !== 4'd4) begin errors++; $display("FAIL bp_rd_count: got %0d, expected 4", rd_count); end
  endtask

  task automatic test_flush();
    int viol = 0;
    bit seen = 1'b0;
    apply_reset();
    en = 1'b1; m_ready = 1'b0;
    write_words(8, 8'h40, 1'b0);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dut.state == FLUSH) begin
        seen = 1'b1;
        if (m_valid) viol++;
      end else if (seen) begin
        break;
      end
      tick();
    end
    checks += 4;
    if (!seen)               begin errors++; $display("FAIL flush_entered: got 0, expected 1"); end
    if (viol != 0)           begin errors++; $display("FAIL flush_m_valid: got %0d cycles valid, expected 0", viol); end
    if (drop_count !== 4'd8) begin errors++; $display("FAIL flush_drop_count: got %0d, expected 8", drop_count); end
    if (dut.state !== RUN)   begin errors++; $display("FAIL flush_exit_state: got %0d, expected %0d", dut.state, RUN); end
    m_ready = 1'b1;
    write_words(1, 8'hAA, 1'b1);
    drain(20);
    tick();
    checks++;
    if (rd_count !== 4'd1) begin errors++; $display("FAIL flush_rd_count: got %0d, expected 1", rd_count); end
  endtask

  task automatic test_disable();
    bit rinc_seen = 1'b0;
    apply_reset();
    en = 1'b1; m_ready = 1'b0;
    write_words(1, 8'h11, 1'b1);
    repeat (4) tick();
    checks++;
    if (dut.occ !== 2'd1) begin errors++; $display("FAIL dis_occ: got %0d, expected 1", dut.occ); end
    en = 1'b0;
    write_words(3, 8'h12, 1'b1);
    repeat (2) tick();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rinc) rinc_seen = 1'b1;
    end
    consume_obs();
    checks += 3;
    if (rd_count !== 4'd1)  begin errors++; $display("FAIL dis_rd_count: got %0d, expected 1", rd_count); end
    if (rinc_seen)          begin errors++; $display("FAIL dis_rinc: got 1, expected 0"); end
    if (exp_q.size() != 3)  begin errors++; $display("FAIL dis_pending: got %0d, expected 3", exp_q.size()); end
    en = 1'b1;
    drain(40);
    tick();
    checks++;
    if (rd_count !== 4'd4) begin errors++; $display("FAIL dis_final_count: got %0d, expected 4", rd_count); end
  endtask

  task automatic test_wrap();
    apply_reset();
    en = 1'b1; m_ready = 1'b1;
    write_words(17, 8'h80, 1'b1);
    drain(100);
    repeat (2) tick();
    checks++;
    if (rd_count !== 4'd1) begin errors++; $display("FAIL wrap_rd_count: got %0d, expected 1", rd_count); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_disable();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
